// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit with a req/ack memory port and a one-cycle response pulse.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning them.
module load_store_unit #(
  parameter int WORD_INDEX_BITS = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [2:0]                 req_funct3,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_data,
  output logic                       resp_misaligned,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WORD_INDEX_BITS-1:0] mem_addr,
  output logic [3:0]                 mem_be,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_RESP = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic                       we_q, we_d;
  logic [WORD_INDEX_BITS-1:0] addr_q, addr_d;
  logic [3:0]                 be_q, be_d;
  logic [31:0]                wdata_q, wdata_d;
  logic [1:0]                 size_q, size_d;
  logic                       uns_q, uns_d;
  logic [1:0]                 lane_q, lane_d;
  logic                       mis_q, mis_d;
  logic [31:0]                resp_data_q, resp_data_d;

  logic                       req_mis_s;
  logic [1:0]                 req_lane_s;
  logic [3:0]                 req_be_s;
  logic [31:0]                req_wdata_s;
  logic [7:0]                 rd_byte_s;
  logic [15:0]                rd_half_s;
  logic [31:0]                load_data_s;
  logic                       unused_addr_s;

  assign unused_addr_s = ^req_addr[31:WORD_INDEX_BITS+2];

  // Request decode: lane (force-aligned for halves/words), byte enables, replicated store data.
  always_comb begin
    req_mis_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                (req_funct3[1] && (req_addr[1:0] != 2'b00));
    case (req_funct3[1:0])
      2'b00: begin
        req_lane_s  = req_addr[1:0];
        req_be_s    = 4'b0001 << req_addr[1:0];
        req_wdata_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_lane_s  = {req_addr[1], 1'b0};
        req_be_s    = 4'b0011 << {req_addr[1], 1'b0};
        req_wdata_s = {2{req_wdata[15:0]}};
      end
      default: begin
        req_lane_s  = 2'b00;
        req_be_s    = 4'b1111;
        req_wdata_s = req_wdata;
      end
    endcase
  end

  // Load extraction: move the addressed lane to bit 0, then sign- or zero-extend.
  always_comb begin
    rd_byte_s = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half_s = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data_s = uns_q ? {24'h000000, rd_byte_s} : {{24{rd_byte_s[7]}}, rd_byte_s};
      2'b01:   load_data_s = uns_q ? {16'h0000, rd_half_s} : {{16{rd_half_s[15]}}, rd_half_s};
      default: load_data_s = mem_rdata;
    endcase
  end

  // Next-state and holding-register update.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    mis_d       = mis_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_write;
          addr_d  = req_addr[WORD_INDEX_BITS+1:2];
          be_d    = req_be_s;
          wdata_d = req_wdata_s;
          size_d  = req_funct3[1:0];
          uns_d   = req_funct3[2];
          lane_d  = req_lane_s;
          mis_d   = TRAP_EN & req_mis_s;
          if (TRAP_EN && req_mis_s) begin
            resp_data_d = 32'h00000000;
            state_d     = S_RESP;
          end else begin
            state_d = S_MEM;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          resp_data_d = we_q ? 32'h00000000 : load_data_s;
          state_d     = S_RESP;
        end else begin
          state_d = S_MEM;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and holding registers; reset clears everything so all outputs read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h00000000;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      mis_q       <= 1'b0;
      resp_data_q <= 32'h00000000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      mis_q       <= mis_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign mem_req         = (state_q == S_MEM);
  assign mem_we          = mem_req & we_q;
  assign mem_addr        = addr_q;
  assign mem_be          = be_q;
  assign mem_wdata       = wdata_q;
  assign resp_valid      = (state_q == S_RESP);
  assign resp_data       = resp_data_q;
  assign resp_misaligned = resp_valid & mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a scoreboard queue and a delayed-ack memory responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned;
  logic [31:0] resp_data;
  logic        mem_req, mem_we, mem_ack;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  load_store_unit #(.WORD_INDEX_BITS(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_misaligned(resp_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [4:0]  e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t tbl[15];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request, act as memory, and check the response against the scoreboard.
  task automatic run_vec(input vec_t v);
    vec_t e;
    int   cyc, mcyc, ack_cyc;
    bit   done, saw_mem;
    @(negedge clk);
    chk("ready_before", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    exp_q.push_back(v);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    cyc = 0; mcyc = 0; ack_cyc = -1; done = 1'b0; saw_mem = 1'b0;
    while (!done && cyc < 50) begin
      if (resp_valid) begin
        mem_ack = 1'b0;
        e = exp_q.pop_front();
        chk("resp_data", resp_data, e.e_data);
        chk("resp_mis", resp_misaligned, e.e_mis);
        chk("resp_ready_low", req_ready, 1'b0);
        chk("resp_cycle", cyc, e.e_mis ? 0 : ack_cyc + 1);
        chk("mem_req_never", saw_mem, !e.e_mis);
        done = 1'b1;
      end else if (mem_req) begin
        saw_mem = 1'b1;
        chk("mem_ready_low", req_ready, 1'b0);
        chk("mem_addr", mem_addr, v.e_addr);
        chk("mem_be", mem_be, v.e_be);
        chk("mem_we", mem_we, v.wr);
        chk("mem_wdata", mem_wdata, v.e_wdata);
        if (mcyc == v.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
          ack_cyc   = cyc;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h0BAD_0BAD;
        end
        mcyc++;
      end else begin
        chk("unexpected_idle", 32'd1, 32'd0);
        cyc = 50;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    if (!done) begin
      chk("resp_timeout", 32'd1, 32'd0);
    end else begin
      chk("resp_one_cycle", resp_valid, 1'b0);
      chk("ready_after", req_ready, 1'b1);
      chk("resp_data_hold", resp_data, v.e_data);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 32'h0000000D, 32'h0, 32'h8899AABB, 0, 5'd3, 4'b0010, 32'h0, 32'hFFFFFFAA, 1'b0};
    tbl[1]  = '{1'b0, 3'b100, 32'h0000000D, 32'h0, 32'h8899AABB, 1, 5'd3, 4'b0010, 32'h0, 32'h000000AA, 1'b0};
    tbl[2]  = '{1'b0, 3'b001, 32'h0000000E, 32'h0, 32'h8899AABB, 0, 5'd3, 4'b1100, 32'h0, 32'hFFFF8899, 1'b0};
    tbl[3]  = '{1'b0, 3'b101, 32'h0000000E, 32'h0, 32'h8899AABB, 2, 5'd3, 4'b1100, 32'h0, 32'h00008899, 1'b0};
    tbl[4]  = '{1'b1, 3'b000, 32'h00000011, 32'h123456CD, 32'h0, 0, 5'd4, 4'b0010, 32'hCDCDCDCD, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 3'b010, 32'h00000004, 32'h0, 32'hDEADBEEF, 5, 5'd1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b0, 3'b000, 32'h0000000C, 32'h0, 32'h8899AABB, 0, 5'd3, 4'b0001, 32'h0, 32'hFFFFFFBB, 1'b0};
    tbl[7]  = '{1'b0, 3'b000, 32'h0000000F, 32'h0, 32'h8899AABB, 0, 5'd3, 4'b1000, 32'h0, 32'hFFFFFF88, 1'b0};
    tbl[8]  = '{1'b0, 3'b001, 32'h0000000C, 32'h0, 32'h8899AABB, 0, 5'd3, 4'b0011, 32'h0, 32'hFFFFAABB, 1'b0};
    tbl[9]  = '{1'b1, 3'b001, 32'h00000002, 32'hAAAA1234, 32'h0, 1, 5'd0, 4'b1100, 32'h12341234, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 3'b010, 32'h0000007C, 32'h0BADF00D, 32'h0, 2, 5'd31, 4'b1111, 32'h0BADF00D, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 3'b011, 32'h00000008, 32'h0, 32'hCAFEF00D, 0, 5'd2, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0};
    tbl[12] = '{1'b1, 3'b000, 32'hFFFFFF83, 32'h0000007F, 32'h0, 0, 5'd0, 4'b1000, 32'h7F7F7F7F, 32'h0, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[13] = '{1'b0, 3'b010, 32'h00000006, 32'h0, 32'h11223344, 0, 5'd1, 4'b1111, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 3'b001, 32'h0000000F, 32'h0000BEEF, 32'h0, 0, 5'd3, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b1};
`else
    tbl[13] = '{1'b0, 3'b010, 32'h00000006, 32'h0, 32'h11223344, 0, 5'd1, 4'b1111, 32'h0, 32'h11223344, 1'b0};
    tbl[14] = '{1'b0, 3'b001, 32'h0000000F, 32'h0, 32'h8899AABB, 0, 5'd3, 4'b1100, 32'h0, 32'hFFFF8899, 1'b0};
`endif

    reset      = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h00000004;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_mis", resp_misaligned, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 5'd0);
    chk("rst_mem_be", mem_be, 4'b0000);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("no_accept_in_reset", mem_req, 1'b0);

    for (int i = 0; i < 15; i++) begin
      run_vec(tbl[i]);
    end

    // A stray ack while idle must not start or complete anything.
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack_ready", req_ready, 1'b1);
      chk("stray_ack_resp", resp_valid, 1'b0);
    end
    mem_ack = 1'b0;
    chk("stray_ack_data", resp_data, 32'hFFFF8899 & {32{!tbl[14].e_mis}});

    // Reset pulse while waiting in MEM.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h00000004;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_mem_req", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_req_drop", mem_req, 1'b0);
    chk("async_resp_valid", resp_valid, 1'b0);
    chk("async_ready", req_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid | mem_req, 1'b0);
    end
    run_vec(tbl[5]);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit that sits directly downstream of the CPU's ALU result. It takes a byte address, store data and funct3 from the execute stage and performs LB/LH/LW/LBU/LHU/SB/SH/SW against a word-organised data memory. The memory side uses a request/acknowledge handshake, and results return as a one-cycle response pulse. The CPU stalls its PC and register write-back between request acceptance and `resp_valid`.

## Interface
- `WORD_INDEX_BITS`, default 5: width of `mem_addr`. It is a word index; the default gives 32 words.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU presents a request.
- `req_ready`  out  1  unit can accept a request (high in IDLE only).
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_addr`  in  32  byte address (ALU result).
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_data`  out  32  extended load data; 0 for stores.
- `resp_misaligned`  out  1  request was rejected as misaligned (see Configuration).
- `mem_req`  out  1  memory access request, held until acknowledged.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  `WORD_INDEX_BITS`  `req_addr[WORD_INDEX_BITS+1:2]`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completed the access; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, MEM, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, the request is captured into holding registers.
  - The next state is RESP if the request is misaligned and trapping is enabled; otherwise MEM.
- MEM:
  - `mem_req`=1, with `mem_we`/`mem_addr`/`mem_be`/`mem_wdata` driven from the captured request and stable.
  - On `mem_ack`, `mem_rdata` is extracted and registered, and the next state is RESP.
  - Without `mem_ack`, the unit stays in MEM indefinitely.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Access size comes from `funct3[1:0]`: 00 byte, 01 half, 10/11 word. `funct3[2]`=1 selects zero-extension for loads.
- Byte enables, where `a` = `addr[1:0]`:
  - byte: `4'b0001<<a`.
  - half: `4'b0011<<{a[1],1'b0}`.
  - word: `4'b1111`.
- Store data lanes: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word `wdata`.
- Load extraction:
  - byte lane `a`, or half lane `a[1]`, is shifted to bit 0.
  - The result is sign- or zero-extended to 32 bits.
- Misaligned means a half access with `a[0]`=1, or a word access with `a`≠0.
- A `mem_ack` seen outside MEM is ignored.
- `resp_misaligned` is 0 on every response unless trapping is enabled and the request was misaligned.

## Timing
- Reset values:
  - state IDLE, so `req_ready`=1; requests are not accepted while `reset` is high.
  - `resp_valid`=0, `resp_data`=0, `resp_misaligned`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
- All outputs are registered or decoded from state and holding registers; there is no combinational path from `req_*` to `mem_*`.
- Request accepted at edge 0 → `mem_req` high from cycle 1. If `mem_ack` arrives in cycle 1+k, `resp_valid` is high in cycle 2+k.
  - Minimum latency is 2 cycles.
  - Maximum throughput is one access per 3 cycles.
- Trapped misaligned request accepted at edge 0 → `resp_valid` in cycle 1 with `resp_misaligned`=1. `mem_req` is never asserted.
- Reset asserted mid-transaction (MEM or RESP):
  - `mem_req` and `resp_valid` drop immediately (asynchronously).
  - The state becomes IDLE and the pending response is discarded.
- `resp_data` holds its value until the next response. Store responses load 0 into it.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests skip memory and complete in RESP with `resp_misaligned`=1 and `resp_data`=0.
  - No memory write occurs.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `resp_misaligned` is tied 0.
  - Misaligned half accesses ignore `a[0]`; misaligned word accesses ignore `a`. The access is force-aligned and proceeds through MEM normally.

## Test plan
- Memory word 3 = `0x8899AABB`:
  - LB (`funct3`=000) at `0x0D` → `mem_addr`=3, `mem_be`=0010, `resp_data`=`0xFFFFFFAA`.
  - LBU at `0x0D` → `0x000000AA`.
- Same memory, LH at `0x0E` → `mem_be`=1100, `resp_data`=`0xFFFF8899`. LHU at `0x0E` → `0x00008899`.
- SB at `0x11` with `req_wdata`=`0x123456CD` → `mem_we`=1, `mem_addr`=4, `mem_be`=0010, `mem_wdata`=`0xCDCDCDCD`, `resp_data`=0.
- `mem_ack` delayed 5 cycles on an LW at `0x04` → `mem_req` and all `mem_*` outputs stable for 5 cycles; `resp_valid` exactly one cycle later, with `req_ready`=0 throughout.
- LW at `0x06`:
  - With `LSU_MISALIGN_TRAP_EN`: `resp_valid` and `resp_misaligned`=1 in cycle 1, `mem_req` never high.
  - Without it: `mem_addr`=1, `mem_be`=1111, `resp_misaligned`=0.
- Reset pulse while in MEM with `mem_ack` low → `mem_req`=0 immediately, no `resp_valid`. After release, `req_ready`=1 and the next LW completes normally.
